// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: round-robin arbiter sharing one UART word port between
// NUM_REQ requesters. One transaction at a time: strobe, wait for response,
// one-cycle ack, then drain the (up to 2-cycle) response before re-arbitrating.
// Optional build macro UART_ARB_TIMEOUT_EN adds a WAIT-state response timeout
// that completes the transaction with req_err = 1.
module uart_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic                  req_err,
    output logic [31:0]           rdata,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy,
    output logic                  uart_read,
    output logic                  uart_write,
    output logic [31:0]           uart_wdata,
    input  logic [31:0]           uart_rdata,
    input  logic                  uart_read_response,
    input  logic                  uart_write_response
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    state_t               state, state_n;
    logic [IW-1:0]        ptr, ptr_n;
    logic [IW-1:0]        idx, idx_n;
    logic                 dir, dir_n;
    logic [31:0]          wdata_q, wdata_n;
    logic [31:0]          rdata_q, rdata_n;
    logic [NUM_REQ-1:0]   ack_q, ack_n;
    logic                 resp;
    logic                 found, hi_found;
    logic [IW-1:0]        lo_pick, hi_pick, pick;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0]          cnt, cnt_n;
    logic                 err_q, err_n;
`else
    logic                 unused_timeout_cfg;
    // Without the timeout build the limit has no hardware behind it.
    assign unused_timeout_cfg = ^TIMEOUT_LIMIT;
`endif

    // Only the response line matching the latched direction counts.
    assign resp = dir ? uart_write_response : uart_read_response;

    // Round-robin pick: lowest requester at/after the pointer, else lowest overall.
    always_comb begin
        found    = 1'b0;
        hi_found = 1'b0;
        lo_pick  = '0;
        hi_pick  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found   = 1'b1;
                lo_pick = IW'(i);
                if (IW'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_pick  = IW'(i);
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    // Next-state and datapath update for the transaction FSM.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = idx;
        dir_n   = dir;
        wdata_n = wdata_q;
        rdata_n = rdata_q;
        ack_n   = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_n   = cnt;
        err_n   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    idx_n   = pick;
                    state_n = ISSUE;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (IW'(i) == pick) begin
                            dir_n   = req_write[i];
                            wdata_n = req_wdata[32*i +: 32];
                        end
                    end
                end
            end
            ISSUE: begin
                state_n = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_n   = '0;
`endif
            end
            WAIT: begin
                if (resp) begin
                    ack_n   = NUM_REQ'(1) << idx;
                    state_n = DRAIN;
                    if (!dir) rdata_n = uart_rdata;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt + 32'd1 == TIMEOUT_LIMIT) begin
                    ack_n   = NUM_REQ'(1) << idx;
                    err_n   = 1'b1;
                    state_n = DRAIN;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
`endif
            end
            DRAIN: begin
                // Hold here through the tail of a 2-cycle response.
                if (!resp) begin
                    state_n = IDLE;
                    ptr_n   = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            idx     <= '0;
            dir     <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt     <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            idx     <= idx_n;
            dir     <= dir_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
            ack_q   <= ack_n;
`ifdef UART_ARB_TIMEOUT_EN
            cnt     <= cnt_n;
            err_q   <= err_n;
`endif
        end
    end

    assign busy       = (state != IDLE);
    assign grant      = busy ? (NUM_REQ'(1) << idx) : '0;
    assign uart_read  = (state == ISSUE) && !dir;
    assign uart_write = (state == ISSUE) && dir;
    assign uart_wdata = wdata_q;
    assign rdata      = rdata_q;
    assign req_ack    = ack_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign req_err    = err_q;
`else
    assign req_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Bench for uart_bus_arbiter: transaction-level reference model compared every
// cycle, a reactive UART responder, directed scenarios and a random phase.
module tb_uart_bus_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_write;
    logic [32*N-1:0] req_wdata;
    logic [N-1:0]    req_ack, grant;
    logic            req_err, busy, uart_read, uart_write;
    logic [31:0]     rdata, uart_wdata, uart_rdata;
    logic            uart_read_response, uart_write_response;

    always #5 clk = ~clk;

    uart_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_err(req_err), .rdata(rdata), .grant(grant),
        .busy(busy), .uart_read(uart_read), .uart_write(uart_write),
        .uart_wdata(uart_wdata), .uart_rdata(uart_rdata),
        .uart_read_response(uart_read_response),
        .uart_write_response(uart_write_response)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction view) ----------------
    int          m_owner = -1;   // requester holding the port, -1 when free
    int          m_ptr   = 0;
    int          m_age   = 0;    // 0: strobe cycle, 1: afterwards
    int          m_waited = 0;   // response-wait cycles seen so far
    bit          m_done  = 0;    // ack already given, now draining
    bit          m_dir   = 0;
    bit          m_ack_now = 0, m_err_now = 0;
    logic [31:0] m_wd = '0, m_rd = '0;

    function automatic void model_edge();
        bit r;
        m_ack_now = 0;
        m_err_now = 0;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_wd = '0; m_rd = '0; m_done = 0; m_age = 0;
            return;
        end
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (req_valid[j]) begin
                    m_owner = j; m_dir = req_write[j]; m_wd = req_wdata[32*j +: 32];
                    m_age = 0; m_done = 0; m_waited = 0;
                    break;
                end
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
            r = m_dir ? uart_write_response : uart_read_response;
            if (!m_done) begin
                m_waited++;
                if (r) begin
                    m_ack_now = 1; m_done = 1;
                    if (!m_dir) m_rd = uart_rdata;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (m_waited == TO) begin
                    m_ack_now = 1; m_err_now = 1; m_done = 1;
                end
`endif
            end else if (!r) begin
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endfunction

    task automatic check_outputs();
        logic [31:0] eg;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk("grant",      32'(grant), eg);
        chk("busy",       32'(busy), 32'(m_owner >= 0));
        chk("uart_read",  32'(uart_read),  32'(m_owner >= 0 && m_age == 0 && !m_dir));
        chk("uart_write", 32'(uart_write), 32'(m_owner >= 0 && m_age == 0 && m_dir));
        chk("uart_wdata", uart_wdata, m_wd);
        chk("req_ack",    32'(req_ack), m_ack_now ? eg : 32'd0);
        chk("req_err",    32'(req_err), 32'(m_err_now));
        chk("rdata",      rdata, m_rd);
    endtask

    // ---------------- UART responder ----------------
    int          u_cd = 0, u_left = 0, u_len = 1;
    bit          u_dir = 0, u_silent = 0, u_rand = 0, u_noise = 0;
    int          u_delay = 1, u_len_fix = 1;
    logic [31:0] u_data = '0;

    task automatic uart_clear();
        u_cd = 0; u_left = 0;
        uart_read_response = 0; uart_write_response = 0;
    endtask

    task automatic uart_step();
        if (u_cd > 0) begin
            u_cd--;
            if (u_cd == 0) u_left = u_len;
        end
        uart_read_response = 0;
        uart_write_response = 0;
        if (u_left > 0) begin
            if (u_dir) uart_write_response = 1; else uart_read_response = 1;
            u_left--;
        end else if (u_noise && $urandom_range(0, 7) == 0) begin
            if (u_dir) uart_read_response = 1; else uart_write_response = 1;
        end
        if (uart_read || uart_write) begin
            u_dir = uart_write;
            if (!u_silent) begin
                if (u_rand) begin
                    u_cd = $urandom_range(1, 5); u_len = $urandom_range(1, 2); uart_rdata = $urandom;
                end else begin
                    u_cd = u_delay; u_len = u_len_fix; uart_rdata = u_data;
                end
            end
        end
    endtask

    // ---------------- requesters ----------------
    bit rand_mode = 0;

    task automatic new_req(input int i);
        req_valid[i] = 1'b1;
        req_write[i] = 1'($urandom_range(0, 1));
        req_wdata[32*i +: 32] = $urandom;
    endtask

    task automatic req_step();
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) begin
                if ($urandom_range(0, 1) == 1) new_req(i); else req_valid[i] = 1'b0;
            end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                new_req(i);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
        uart_step();
        if (rand_mode) req_step();
    endtask

    // ---------------- observation helpers ----------------
    int          n_strobe, n_ack, n_overlap, first_strobe, first_ack;
    logic [N-1:0] last_ack;
    logic        last_err;
    logic [31:0] ack_rdata, st_wdata;
    int          ack_order[$];

    task automatic clr_stats();
        n_strobe = 0; n_ack = 0; n_overlap = 0; first_strobe = -1; first_ack = -1;
        last_ack = '0; last_err = 0; ack_rdata = '0; st_wdata = '0;
        ack_order.delete();
    endtask

    task automatic observe(input int ncyc, input bit rereq);
        for (int n = 0; n < ncyc; n++) begin
            tick();
            if (uart_read && uart_write) n_overlap++;
            if (uart_read || uart_write) begin
                n_strobe++; st_wdata = uart_wdata;
                if (first_strobe < 0) first_strobe = cyc;
            end
            if (req_ack != '0) begin
                n_ack++; last_ack = req_ack; last_err = req_err; ack_rdata = rdata;
                if (first_ack < 0) first_ack = cyc;
                for (int i = 0; i < N; i++) begin
                    if (req_ack[i]) begin
                        ack_order.push_back(i);
                        if (!rereq) req_valid[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        uart_clear();
        for (int k = 0; k < n; k++) tick();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish cycle=%0d", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int racks;
        reset = 1'b1; req_valid = '0; req_write = '0; req_wdata = '0;
        uart_rdata = '0; uart_read_response = 0; uart_write_response = 0;
        do_reset(2);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_busy",  32'(busy), 32'd0);
        chk("reset_rdata", rdata, 32'd0);

        // Requester 0 writes, UART answers 3 cycles after strobe for 2 cycles.
        u_delay = 3; u_len_fix = 2;
        req_valid[0] = 1; req_write[0] = 1; req_wdata[31:0] = 32'hDEADBEEF;
        clr_stats();
        observe(20, 0);
        chk("t1_strobes", n_strobe, 1);
        chk("t1_wdata",   st_wdata, 32'hDEADBEEF);
        chk("t1_acks",    n_ack, 1);
        chk("t1_ackvec",  32'(last_ack), 32'd1);
        chk("t1_err",     32'(last_err), 0);
        chk("t1_idle",    32'(busy), 0);

        // Requester 1 reads 0x12345678 with a 2-cycle response.
        u_delay = 2; u_len_fix = 2; u_data = 32'h12345678;
        req_valid[1] = 1; req_write[1] = 0; req_wdata[63:32] = 32'h0;
        clr_stats();
        observe(20, 0);
        chk("t2_acks",   n_ack, 1);
        chk("t2_ackvec", 32'(last_ack), 32'd2);
        chk("t2_rdata",  ack_rdata, 32'h12345678);

        // Both requesters continuously active from reset: 0,1,0,1.
        do_reset(2);
        u_delay = 1; u_len_fix = 2; u_data = 32'h0BADF00D;
        req_valid = 2'b11; req_write = 2'b01;
        clr_stats();
        observe(40, 1);
        req_valid = '0;
        observe(10, 0);
        chk("t3_count",   32'(ack_order.size() >= 4), 1);
        if (ack_order.size() >= 4) begin
            chk("t3_order0", ack_order[0], 0);
            chk("t3_order1", ack_order[1], 1);
            chk("t3_order2", ack_order[2], 0);
            chk("t3_order3", ack_order[3], 1);
        end
        chk("t3_overlap", n_overlap, 0);

        // Reset while waiting for the UART response.
        u_delay = 5; u_len_fix = 1;
        req_valid[0] = 1; req_write[0] = 0;
        clr_stats();
        for (int k = 0; k < 10 && n_strobe == 0; k++) observe(1, 0);
        chk("t4_strobe_seen", n_strobe, 1);
        tick();
        req_valid = '0;
        do_reset(1);
        chk("t4_grant", 32'(grant), 0);
        chk("t4_busy",  32'(busy), 0);
        chk("t4_ack",   32'(req_ack), 0);
        chk("t4_strb",  32'({uart_read, uart_write}), 0);
        chk("t4_rdata", rdata, 0);
        chk("t4_wdata", uart_wdata, 0);
        req_valid[1] = 1; req_write[1] = 1; req_wdata[63:32] = 32'hCAFE0001;
        tick();
        chk("t4_first_grant", 32'(grant), 32'd2);
        clr_stats();
        observe(15, 0);
        chk("t4_acks", n_ack, 1);

        // Response 1 cycle after the strobe: ack in the 4th cycle of the request.
        u_delay = 1; u_len_fix = 1; u_data = 32'hA5A50001;
        req_valid[0] = 1; req_write[0] = 0;
        clr_stats();
        first_strobe = cyc;
        observe(12, 0);
        chk("t5_latency", first_ack - first_strobe + 1, 4);
        chk("t5_rdata",   ack_rdata, 32'hA5A50001);

`ifdef UART_ARB_TIMEOUT_EN
        // No response: timeout ack with err after 16 wait cycles.
        u_silent = 1;
        req_valid[0] = 1; req_write[0] = 0;
        clr_stats();
        observe(30, 0);
        chk("t6_wait_cycles", first_ack - first_strobe, TO + 1);
        chk("t6_err",   32'(last_err), 1);
        chk("t6_ackvec", 32'(last_ack), 32'd1);
        chk("t6_rdata", ack_rdata, 32'hA5A50001);
        u_silent = 0; u_delay = 2; u_len_fix = 2;
        req_valid[1] = 1; req_write[1] = 1; req_wdata[63:32] = 32'h600DD00D;
        clr_stats();
        observe(15, 0);
        chk("t6_next_acks", n_ack, 1);
        chk("t6_next_err",  32'(last_err), 0);
        chk("t6_next_vec",  32'(last_ack), 32'd2);
`endif

        // Random traffic with noise on the unused response line.
        do_reset(2);
        u_rand = 1; u_noise = 1; rand_mode = 1; racks = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset(2);
            tick();
            if (req_ack != '0) racks++;
        end
        rand_mode = 0; u_noise = 0;
        req_valid = '0;
        for (int n = 0; n < 20; n++) tick();
        chk("rand_activity", 32'(racks > 100), 1);
        chk("rand_final_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_bus_arbiter.md
Name: uart_bus_arbiter

Overview:
- Shares one UART word-access port between NUM_REQ requesters, e.g. the controller core and a debug or loader unit.
- The shared port has read/write strobes, 32-bit write data, 32-bit read data and read/write response pulses.
- Grants one transaction at a time using round-robin priority.
- Issues a single-cycle strobe to the UART, waits for its response, then returns a one-cycle ack to the winning requester.
- Sits between the requesters and the UART wrapper instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1000000, cycles to wait for a UART response before aborting. Used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request. Held high until the matching ack.
- req_write  input  NUM_REQ  per-requester direction: 1 = write, 0 = read. Stable while req_valid is high.
- req_wdata  input  32*NUM_REQ  per-requester write word. Requester i uses bits [32*i+31:32*i].
- req_ack  output  NUM_REQ  one-hot, one-cycle completion pulse
- req_err  output  1  valid with req_ack. 1 = transaction timed out.
- rdata  output  32  read word, valid in the req_ack cycle
- grant  output  NUM_REQ  one-hot index of the current owner. 0 when idle.
- busy  output  1  high in any state other than IDLE
- uart_read  output  1  read strobe to the UART
- uart_write  output  1  write strobe to the UART
- uart_wdata  output  32  write word to the UART
- uart_rdata  input  32  UART read word
- uart_read_response  input  1  UART read-done. May stay high for 2 consecutive cycles.
- uart_write_response  input  1  UART write-done. May stay high for 2 consecutive cycles.

Behaviour:
- Reset: all outputs are 0, state is IDLE, round-robin pointer is 0, timeout counter is 0. The reset is synchronous and applies mid-transaction.
- After a mid-transaction reset, the UART may still emit responses. DRAIN on the next transaction does not cover this; the system must reset the UART together with the arbiter.
- resp = uart_read_response when the latched direction is read; resp = uart_write_response when it is write.

States:
- IDLE:
  - If any req_valid is high, select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch the index, direction and wdata; set grant; go to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE:
  - Drive uart_read or uart_write high for exactly one cycle, according to the latched direction.
  - Present uart_wdata from the latch and hold it until return to IDLE.
  - Go to WAIT.
- WAIT:
  - On the first cycle that resp is high: capture uart_rdata into rdata (read only), pulse req_ack[index], req_err = 0, go to DRAIN.
  - Responses on the other response line are ignored.
- DRAIN:
  - Stay while resp is high. When resp is low, go to IDLE.
  - Set pointer = (index + 1) mod NUM_REQ; clear grant.
  - This absorbs the UART's 2-cycle response so it is never taken as a second completion.

Rules:
- Back-to-back transactions: minimum requester-visible latency from req_valid to req_ack is 4 cycles (IDLE, ISSUE, WAIT with immediate response, ack registered).
- A granted requester keeps the grant until its ack. Dropping req_valid mid-transaction is illegal; the transaction still completes and still acks.
- rdata holds its last value outside ack cycles. It is not updated on writes.
- Simultaneous requests: round-robin order. With all requesters continuously active, each is served once per NUM_REQ transactions.
- The same requester re-asserting right after its ack loses to any other pending requester.
- A read blocks while the UART RX FIFO is empty. The arbiter waits indefinitely unless the optional timeout is compiled in.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- When defined:
  - A 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no resp, pulse req_ack[index] with req_err = 1, leave rdata unchanged, go to DRAIN, and advance the pointer.
  - A response arriving in the same cycle as expiry wins: req_err = 0.
- When undefined: no counter is built, req_err is tied to 0, and WAIT lasts until resp.

Test Plan:
- Requester 0 writes 0xDEADBEEF; the UART model responds 3 cycles after the strobe for 2 cycles -> exactly one uart_write pulse, uart_wdata = 0xDEADBEEF, one req_ack = 2'b01, req_err = 0, busy low afterwards.
- Requester 1 reads; the model returns 0x12345678 with a 2-cycle response -> rdata = 0x12345678 in the req_ack = 2'b10 cycle, and no second ack.
- Both requesters held valid for 4 transactions from reset -> grants in order 0,1,0,1, with no strobe overlap.
- Reset asserted in WAIT -> next cycle all outputs are 0 and state is IDLE; a new request from requester 1 is granted first, since the pointer is 0 and requester 0 is idle.
- Response arrives 1 cycle after the strobe -> req_ack occurs 4 cycles after req_valid rose.
- With UART_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES = 16, a read is issued with no response -> req_ack and req_err = 1 exactly 16 WAIT cycles after entry, rdata unchanged, and the next request is serviced normally.
